// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32I core.
// Holds PC-source select, fetch FSM states and the NOP encoding.
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JALR   = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC target select: PC+4, PC+imm or jalr target.
// In: pc, pc_src, imm_ext, alu_result. Out: target, misaligned.
module pc_next_mux
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm_ext,
  input  logic [31:0] alu_result,
  output logic [31:0] target,
  output logic        misaligned
);

  always_comb begin
    target = pc + 32'd4;
    unique case (1'b1)
      (pc_src == PC_BRANCH): target = pc + imm_ext;
      (pc_src == PC_JALR):   target = alu_result & ~32'd1;
      default: ;
    endcase
    misaligned = |target[1:0];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, ROM drive, retire count, trap.
// In: clk, rst_n, pc_src, imm_ext, alu_result, stall, imem_rdata.
// Out: imem_addr, imem_en, instr, instr_valid, pc, pc_plus4,
//      trap, trap_pc, instret.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        pc_src,
  input  logic [31:0]       imm_ext,
  input  logic [31:0]       alu_result,
  input  logic              stall,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              trap,
  output logic [31:0]       trap_pc,
  output logic [31:0]       instret
);

  fetch_state_t state;
  fetch_state_t nextState;
  logic [31:0]  target;
  logic         misaligned;
  logic [31:0]  pcNext;
  logic         retire;
  logic         trapSet;

  pc_next_mux uMux (
    .pc         (pc),
    .pc_src     (pc_src),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .target     (target),
    .misaligned (misaligned)
  );

  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      instret <= '0;
      trap    <= 1'b0;
      trap_pc <= '0;
    end else begin
      state <= nextState;
      pc    <= pcNext;
      if (retire) instret <= instret + 32'd1;
      if (trapSet) begin
        trap    <= 1'b1;
        trap_pc <= target;
      end
    end
  end

  always_comb begin
    nextState   = state;
    pcNext      = pc;
    retire      = 1'b0;
    trapSet     = 1'b0;
    imem_addr   = pc[ADDR_W-1:0];
    imem_en     = 1'b1;
    instr       = NOP_INSTR;
    instr_valid = 1'b0;
    unique case (state)
      BOOT: begin
        imem_addr = RESET_PC[ADDR_W-1:0];
        nextState = RUN;
      end
      RUN: begin
        instr_valid = 1'b1;
        instr       = imem_rdata;
        // Stall re-reads the current word so instr stays stable.
        if (stall) begin
          imem_addr = pc[ADDR_W-1:0];
        end else if (misaligned) begin
          imem_addr = target[ADDR_W-1:0];
          nextState = HALT;
          trapSet   = 1'b1;
          retire    = 1'b1;
        end else begin
          imem_addr = target[ADDR_W-1:0];
          pcNext    = target;
          retire    = 1'b1;
        end
      end
      HALT: begin
        imem_en = 1'b0;
      end
      default: begin
        nextState = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Uses a 12-bit and a 4-bit address instance with ROM models.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pc_src;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
  logic        stall;

  logic [11:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap;
  logic [31:0] trap_pc;
  logic [31:0] instret;

  logic [3:0]  addr4;
  logic        en4;
  logic [31:0] rdata4;
  logic [31:0] instr4;
  logic        valid4;
  logic [31:0] pc4;
  logic [31:0] pcp4_4;
  logic        trap4;
  logic [31:0] trapPc4;
  logic [31:0] instret4;

  logic [31:0] rom  [0:1023];
  logic [31:0] rom4 [0:3];

  int checks;
  int failures;

  fetch_unit #(.RESET_PC(32'h0), .ADDR_W(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_src      (pc_src),
    .imm_ext     (imm_ext),
    .alu_result  (alu_result),
    .stall       (stall),
    .imem_addr   (imem_addr),
    .imem_en     (imem_en),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .trap        (trap),
    .trap_pc     (trap_pc),
    .instret     (instret)
  );

  fetch_unit #(.RESET_PC(32'h0), .ADDR_W(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_src      (pc_src),
    .imm_ext     (imm_ext),
    .alu_result  (alu_result),
    .stall       (stall),
    .imem_addr   (addr4),
    .imem_en     (en4),
    .imem_rdata  (rdata4),
    .instr       (instr4),
    .instr_valid (valid4),
    .pc          (pc4),
    .pc_plus4    (pcp4_4),
    .trap        (trap4),
    .trap_pc     (trapPc4),
    .instret     (instret4)
  );

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h100 + i;
    for (int i = 0; i < 4; i++) rom4[i] = 32'h100 + i;
  end

  always_ff @(posedge clk) begin
    if (imem_en) imem_rdata <= rom[imem_addr[11:2]];
    if (en4) rdata4 <= rom4[addr4[3:2]];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    pc_src = 2'd0;
    imm_ext = 32'h0;
    alu_result = 32'h0;
    stall = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    pc_src = 2'd0;
    imm_ext = 32'h0;
    alu_result = 32'h0;
    stall = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0) begin
      failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0);
    end
    checks++;
    if (pc_plus4 !== 32'h4) begin
      failures++; $display("FAIL reset_pcp4 got=%h exp=%h", pc_plus4, 32'h4);
    end
    checks++;
    if (instr !== NOP || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_instr got=%h/%b exp=%h/0", instr, instr_valid, NOP);
    end
    checks++;
    if (trap !== 1'b0 || trap_pc !== 32'h0 || instret !== 32'h0) begin
      failures++;
      $display("FAIL reset_trap got=%b/%h/%h exp=0/0/0", trap, trap_pc, instret);
    end
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== 12'h0) begin
      failures++;
      $display("FAIL reset_imem got=%b/%h exp=1/000", imem_en, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (pc !== 32'h0 || instr !== 32'h100 || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL first_fetch got=%h/%h/%b exp=0/100/1", pc, instr, instr_valid);
    end
    step(3);
    checks++;
    if (pc !== 32'hC || instr !== 32'h103 || instret !== 32'd3) begin
      failures++;
      $display("FAIL seq3 got=%h/%h/%0d exp=c/103/3", pc, instr, instret);
    end
  endtask

  task automatic test_branch();
    doReset();
    step(2);
    pc_src = 2'd1;
    imm_ext = 32'hFFFF_FFF8;
    #1;
    checks++;
    if (imem_addr !== 12'h0) begin
      failures++; $display("FAIL br_addr got=%h exp=000", imem_addr);
    end
    step(1);
    pc_src = 2'd0;
    checks++;
    if (pc !== 32'h0 || instr !== 32'h100 || pc_plus4 !== 32'h4) begin
      failures++;
      $display("FAIL br_target got=%h/%h/%h exp=0/100/4", pc, instr, pc_plus4);
    end
  endtask

  task automatic test_jalr();
    doReset();
    pc_src = 2'd2;
    alu_result = 32'h101;
    step(1);
    pc_src = 2'd0;
    checks++;
    if (pc !== 32'h100 || pc_plus4 !== 32'h104) begin
      failures++; $display("FAIL jalr_pc got=%h/%h exp=100/104", pc, pc_plus4);
    end
    checks++;
    if (instr !== 32'h140 || instret !== 32'd1) begin
      failures++; $display("FAIL jalr_instr got=%h/%0d exp=140/1", instr, instret);
    end
    doReset();
    step(1);
    pc_src = 2'd3;
    step(1);
    pc_src = 2'd0;
    checks++;
    if (pc !== 32'h8 || instr !== 32'h102) begin
      failures++; $display("FAIL src3 got=%h/%h exp=8/102", pc, instr);
    end
  endtask

  task automatic test_stall();
    doReset();
    step(4);
    stall = 1'b1;
    #1;
    checks++;
    if (imem_addr !== 12'h10) begin
      failures++; $display("FAIL stall_addr got=%h exp=010", imem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      step(1);
      checks++;
      if (pc !== 32'h10 || instr !== 32'h104 || instret !== 32'd4) begin
        failures++;
        $display("FAIL stall_hold%0d got=%h/%h/%0d exp=10/104/4",
                 i, pc, instr, instret);
      end
    end
    stall = 1'b0;
    step(1);
    checks++;
    if (pc !== 32'h14 || instr !== 32'h105 || instret !== 32'd5) begin
      failures++;
      $display("FAIL stall_rel got=%h/%h/%0d exp=14/105/5", pc, instr, instret);
    end
  endtask

  task automatic test_misaligned();
    doReset();
    step(1);
    pc_src = 2'd1;
    imm_ext = 32'h6;
    stall = 1'b1;
    step(1);
    checks++;
    if (trap !== 1'b0 || pc !== 32'h4 || instret !== 32'd1) begin
      failures++;
      $display("FAIL mis_stall got=%b/%h/%0d exp=0/4/1", trap, pc, instret);
    end
    stall = 1'b0;
    step(1);
    checks++;
    if (trap !== 1'b1 || trap_pc !== 32'hA) begin
      failures++; $display("FAIL mis_trap got=%b/%h exp=1/a", trap, trap_pc);
    end
    checks++;
    if (instr_valid !== 1'b0 || imem_en !== 1'b0 || instr !== NOP) begin
      failures++;
      $display("FAIL mis_out got=%b/%b/%h exp=0/0/%h", instr_valid, imem_en, instr, NOP);
    end
    checks++;
    if (pc !== 32'h4 || instret !== 32'd2 || imem_addr !== 12'h4) begin
      failures++;
      $display("FAIL mis_pc got=%h/%0d/%h exp=4/2/004", pc, instret, imem_addr);
    end
    for (int i = 0; i < 5; i++) begin
      pc_src = 2'($urandom_range(0, 3));
      imm_ext = $urandom;
      alu_result = $urandom;
      stall = 1'($urandom_range(0, 1));
      step(1);
      checks++;
      if (trap !== 1'b1 || trap_pc !== 32'hA || pc !== 32'h4 ||
          instret !== 32'd2 || instr_valid !== 1'b0 || imem_en !== 1'b0) begin
        failures++;
        $display("FAIL halt_hold%0d got=%b/%h/%h/%0d/%b/%b exp=1/a/4/2/0/0",
                 i, trap, trap_pc, pc, instret, instr_valid, imem_en);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || pc_plus4 !== 32'h4 || instret !== 32'h0) begin
      failures++;
      $display("FAIL mid_rst_pc got=%h/%h/%h exp=0/4/0", pc, pc_plus4, instret);
    end
    checks++;
    if (trap !== 1'b0 || trap_pc !== 32'h0 || instr !== NOP ||
        instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_trap got=%b/%h/%h/%b exp=0/0/%h/0",
               trap, trap_pc, instr, instr_valid, NOP);
    end
    checks++;
    if (imem_en !== 1'b1 || imem_addr !== 12'h0) begin
      failures++; $display("FAIL mid_rst_imem got=%b/%h exp=1/000", imem_en, imem_addr);
    end
    @(negedge clk);
    pc_src = 2'd0;
    imm_ext = 32'h0;
    alu_result = 32'h0;
    stall = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (pc !== 32'h0 || instr !== 32'h100 || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL post_rst got=%h/%h/%b exp=0/100/1", pc, instr, instr_valid);
    end
  endtask

  task automatic test_wrap();
    doReset();
    step(3);
    #1;
    checks++;
    if (pc4 !== 32'hC || instr4 !== 32'h103 || addr4 !== 4'h0) begin
      failures++;
      $display("FAIL wrap_pre got=%h/%h/%h exp=c/103/0", pc4, instr4, addr4);
    end
    step(1);
    checks++;
    if (pc4 !== 32'h10 || instr4 !== 32'h100 || pcp4_4 !== 32'h14) begin
      failures++;
      $display("FAIL wrap_post got=%h/%h/%h exp=10/100/14", pc4, instr4, pcp4_4);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_branch();
    test_jalr();
    test_stall();
    test_misaligned();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-cycle RV32I core. It holds the program counter and drives the synchronous instruction ROM. It presents the current instruction to the decoder/control stage. It computes the next PC from the control stage's PC-source select, the extended immediate and the ALU result. It also supplies PC+4 for link write-back, counts retired instructions, and halts on a misaligned fetch target.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address; must be word-aligned.
- `ADDR_W`, default 12: instruction-ROM byte-address width.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pc_src` in 2: 0 = PC+4, 1 = PC+imm_ext (branch taken / jal), 2 = alu_result with bit 0 cleared (jalr), 3 = illegal, treated as 0.
- `imm_ext` in 32: sign-extended immediate from the extend unit.
- `alu_result` in 32: jalr target.
- `stall` in 1: hold the current instruction.
- `imem_addr` out ADDR_W: ROM read address, combinational.
- `imem_en` out 1: ROM read enable.
- `imem_rdata` in 32: ROM data, registered inside the ROM with 1-cycle latency.
- `instr` out 32: instruction to decode; NOP (32'h0000_0013) when not valid.
- `instr_valid` out 1: `instr`/`pc` describe a live instruction.
- `pc` out 32: address of `instr`.
- `pc_plus4` out 32: `pc`+4.
- `trap` out 1: misaligned target detected; sticky.
- `trap_pc` out 32: the offending target.
- `instret` out 32: retired-instruction count.

## Operation
- States: BOOT, RUN, HALT (enum in package).
- BOOT
  - Entered on reset.
  - `imem_addr`=RESET_PC[ADDR_W-1:0], `imem_en`=1, `instr_valid`=0.
  - Next edge → RUN. `pc` is unchanged.
- RUN, `instr_valid`=1, `instr`=`imem_rdata`.
  - target = per `pc_src`. Arithmetic is 32-bit, wrap-around, no overflow flag.
  - `stall`=1: next_pc=`pc`, `imem_addr`=`pc`. `pc`, `instr` and `instret` hold, because the ROM re-reads the same word.
  - `stall`=0 and target[1:0]==0: next_pc=target, `imem_addr`=target[ADDR_W-1:0]. On the edge, `pc`←target and `instret`++ (wraps at 2^32).
  - `stall`=0 and target[1:0]!=0: → HALT on the edge. `trap_pc`←target, `trap`←1, `instret`++. `pc` holds.
- HALT
  - `instr_valid`=0, `instr`=NOP, `imem_en`=0, `imem_addr`=`pc`.
  - All inputs are ignored. The block leaves HALT only through reset.
- `stall` takes precedence over the misalignment check: a stalled misaligned target does not trap until `stall`=0.
- `imem_addr` truncates to ADDR_W bits, so the fetch wraps modulo 2^ADDR_W. `pc` keeps the full 32 bits.

## Timing
- Reset values, applied immediately on `rst_n` falling, including mid-operation:
  - `pc`=RESET_PC, `pc_plus4`=RESET_PC+4.
  - `instr`=NOP, `instr_valid`=0.
  - `trap`=0, `trap_pc`=0, `instret`=0.
  - `imem_en`=1, `imem_addr`=RESET_PC[ADDR_W-1:0].
  - State = BOOT.
- First valid instruction: the first rising edge after `rst_n` rises.
- Redirect latency is zero bubbles: the target is on `imem_addr` in the same cycle as `pc_src`, and the target instruction is valid on the next cycle.
- `pc_src`, `imm_ext`, `alu_result` and `stall` are sampled only in RUN and are combinational from decode. `imem_addr` is the only combinational output path.
- `pc_plus4` is combinational from the `pc` register.

## Structure
- `cpu_pkg` holds:
  - `pc_src_t` enum (PC_SEQ=0, PC_BRANCH=1, PC_JALR=2).
  - `fetch_state_t` (BOOT, RUN, HALT).
  - constant NOP_INSTR = 32'h0000_0013.
- Sub-module `pc_next_mux`: combinational. Inputs are `pc`, `pc_src`, `imm_ext`, `alu_result`. Outputs are the target and a misaligned flag.
- `fetch_unit` holds the state register, `pc`, `instret`, `trap`/`trap_pc` and the output muxing.

## Test plan
- Reset release, RESET_PC=0, ROM word n = 0x100+n, no stall:
  - Cycle 1: `pc`=0, `instr`=0x100, `instr_valid`=1.
  - After 3 more edges: `pc`=0xC, `instr`=0x103, `instret`=3.
- Branch: at `pc`=0x8, `pc_src`=1, `imm_ext`=0xFFFF_FFF8 → `imem_addr`=0x0 the same cycle; next cycle `pc`=0, `instr`=0x100.
- jalr: `pc_src`=2, `alu_result`=0x101 → next `pc`=0x100 and `pc_plus4`=0x104. Also `pc_src`=3 at `pc`=0x4 → `pc`=0x8.
- Stall for 2 cycles at `pc`=0x10:
  - `pc`, `instr` and `instret` hold; `imem_addr`=0x10.
  - Release → `pc`=0x14 on the next edge.
- Misaligned: at `pc`=0x4, `pc_src`=1, `imm_ext`=6:
  - Next cycle: `trap`=1, `trap_pc`=0xA, `instr_valid`=0, `imem_en`=0, `pc`=0x4.
  - Holds for 5 cycles despite input activity.
  - `rst_n` low mid-cycle → all outputs at reset values before the next edge.
- ADDR_W=4 wrap: `pc`=0xC sequential → `pc`=0x10, `imem_addr`=0x0, `instr`=ROM word 0.
